// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// Module      : pipe_pkg
// Description : Shared encodings for the 5-stage pipeline control logic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

    localparam logic [1:0] CTRLMEM_LOAD  = 2'b01;
    localparam logic [1:0] CTRLMEM_STORE = 2'b10;
    localparam logic [1:0] CTRLMEM_NONE  = 2'b11;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_t;

    // Reserved encoding 2'b00 falls through as "no access".
    function automatic logic is_mem_access(input logic [1:0] ctrlmem);
        return (ctrlmem == CTRLMEM_LOAD) || (ctrlmem == CTRLMEM_STORE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//------------------------------------------------------------------------------
// Module      : sat_counter
// Description : Up counter that sticks at all-ones, with synchronous clear.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] c_MAX = '1;

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != c_MAX)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : hazard_ctrl
// Description : Pipeline stall/flush controller with bus-timeout detection
//               and saturating stall/flush performance counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter logic [15:0] IRAM_TOP = 16'h8000,
    parameter int          WAIT_MAX = 255,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rreg1,
    input  logic [3:0]       id_rreg2,
    input  logic [3:0]       ex_wreg,
    input  logic [1:0]       ex_ctrlmem,
    input  logic             br_taken,
    input  logic [1:0]       mem_ctrlmem,
    input  logic [15:0]      mem_addr,
    input  logic             mem_busy,
    output logic             pc_keep,
    output logic             if_keep,
    output logic             if_clear,
    output logic             id_keep,
    output logic             id_clear,
    output logic             ex_keep,
    output logic             mem_clear,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int               c_WC_W      = $clog2(WAIT_MAX + 1);
    localparam logic [c_WC_W-1:0] c_WAIT_MAX  = c_WC_W'(WAIT_MAX);
    localparam logic [c_WC_W-1:0] c_WAIT_LAST = c_WC_W'(WAIT_MAX - 1);

    hz_state_t         r_state;
    logic [c_WC_W-1:0] r_wait_cnt;
    logic              r_bus_err;

    logic w_lu;
    logic w_sh;
    logic w_flush;

    assign w_lu = (ex_ctrlmem == CTRLMEM_LOAD) && (ex_wreg != REG_NONE) &&
                  (((ex_wreg == id_rreg1) && (id_rreg1 != REG_NONE)) ||
                   ((ex_wreg == id_rreg2) && (id_rreg2 != REG_NONE)));

    assign w_sh = is_mem_access(mem_ctrlmem) && (mem_addr < IRAM_TOP);

    // A branch held in EX during mem_busy is only acted on once EX is released.
    assign w_flush = !rst && !mem_busy && br_taken;

    always_comb begin
        pc_keep   = 1'b0;
        if_keep   = 1'b0;
        if_clear  = 1'b0;
        id_keep   = 1'b0;
        id_clear  = 1'b0;
        ex_keep   = 1'b0;
        mem_clear = 1'b0;
        if (rst) begin
            if_clear  = 1'b1;
            id_clear  = 1'b1;
            mem_clear = 1'b1;
        end else if (mem_busy) begin
            pc_keep   = 1'b1;
            if_keep   = 1'b1;
            id_keep   = 1'b1;
            ex_keep   = 1'b1;
            mem_clear = 1'b1;
        end else if (br_taken) begin
            if_clear  = 1'b1;
            id_clear  = 1'b1;
        end else if (w_sh) begin
            pc_keep   = 1'b1;
            if_clear  = 1'b1;
        end else if (w_lu) begin
            pc_keep   = 1'b1;
            if_keep   = 1'b1;
            id_clear  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_wait_cnt <= '0;
                    if (mem_busy) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_busy) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        if (r_wait_cnt != c_WAIT_MAX) begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                        // Flag raised on the same edge the counter lands on WAIT_MAX.
                        if (r_wait_cnt >= c_WAIT_LAST) begin
                            r_bus_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign bus_err = r_bus_err;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_keep),
        .clr (1'b0),
        .q   (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_flush),
        .clr (1'b0),
        .q   (flush_cnt)
    );

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline. It is the producer of the keep/clear pairs consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- It detects four hazards and drives the matching controls: load-use, RAM structural conflict (IF vs MEM on the shared instruction RAM), taken branch/jump in EX, and multi-cycle memory/peripheral access (mem_busy).
- It holds a small wait FSM, a bus-timeout counter and two saturating performance counters.

Parameters:
- IRAM_TOP, 16'h8000: addresses strictly below this are in instruction RAM; a MEM access there conflicts with fetch.
- WAIT_MAX, 255: maximum consecutive mem_busy cycles before bus_err is set.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock. All state updates on posedge; outputs settle before the pipeline registers' negedge capture.
- rst  in  1  asynchronous, active-high reset.
- id_rreg1  in  4  ID-stage source reg 1; 4'hF = none.
- id_rreg2  in  4  ID-stage source reg 2; 4'hF = none.
- ex_wreg  in  4  EX-stage (ID/EX output) dest reg; 4'hF = none.
- ex_ctrlmem  in  2  EX mem op: 01 load, 10 store, 11 none, 00 reserved (treated as none).
- br_taken  in  1  EX-stage branch/jump resolved taken.
- mem_ctrlmem  in  2  MEM-stage mem op, same encoding as ex_ctrlmem.
- mem_addr  in  16  MEM-stage address.
- mem_busy  in  1  memory controller not done this cycle.
- pc_keep  out  1  hold PC.
- if_keep  out  1  hold IF/ID.
- if_clear  out  1  load bubble into IF/ID.
- id_keep  out  1  hold ID/EX.
- id_clear  out  1  load bubble into ID/EX.
- ex_keep  out  1  hold EX/MEM.
- mem_clear  out  1  load bubble into MEM/WB.
- bus_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  cycles with pc_keep=1, saturating.
- flush_cnt  out  CNT_W  taken-branch flushes, saturating.

Behaviour:
- Reset (rst=1, async):
  - Registered state: state=RUN, wait counter=0, bus_err=0, stall_cnt=0, flush_cnt=0.
  - Combinational outputs while rst=1: all *_keep=0; if_clear, id_clear and mem_clear =1 (pipeline flushed).
  - First posedge after release is a normal RUN cycle.
- Hazard terms (combinational):
  - LU = (ex_ctrlmem==01) & (ex_wreg!=F) & ((ex_wreg==id_rreg1 & id_rreg1!=F) | (ex_wreg==id_rreg2 & id_rreg2!=F)).
  - SH = (mem_ctrlmem==01 | mem_ctrlmem==10) & (mem_addr < IRAM_TOP).
- Priority: mem_busy > br_taken > SH > LU. Only the winner's outputs are driven; all other outputs are 0.
- mem_busy: pc_keep=if_keep=id_keep=ex_keep=1, mem_clear=1.
- br_taken: if_clear=1, id_clear=1; PC loads target (pc_keep=0). Exactly one cycle per taken branch.
- SH: pc_keep=1, if_clear=1; ID/EX onward advance.
- LU: pc_keep=1, if_keep=1, id_clear=1. This lasts one cycle; the bubble removes the condition on the next cycle.
- SH and LU together: SH wins this cycle; LU is re-evaluated next cycle.
- FSM, states RUN and WAIT:
  - RUN -> WAIT when mem_busy=1 at posedge.
  - WAIT -> RUN when mem_busy=0.
  - Outputs depend on current inputs, not on state; state only qualifies counting.
- Wait counter:
  - Cleared in RUN; increments in WAIT while mem_busy=1.
  - When it reaches WAIT_MAX with mem_busy still 1, bus_err sets and stays set until rst.
  - The pipeline stays stalled; the counter holds at WAIT_MAX.
- br_taken during mem_busy is ignored, because EX is held. It is acted on in the first cycle with mem_busy=0, since EX still presents the same instruction.
- stall_cnt: +1 at each posedge with pc_keep=1; saturates at all-ones.
- flush_cnt: +1 at each posedge where br_taken wins priority; saturates.
- Reset mid-WAIT: outputs return to the reset values immediately, and the counter clears.

Decomposition:
- Shared package (pipe_pkg):
  - CTRLMEM_LOAD=2'b01, CTRLMEM_STORE=2'b10, CTRLMEM_NONE=2'b11.
  - REG_NONE=4'hF.
  - FSM state enum {RUN, WAIT}.
- One natural sub-module: sat_counter (width parameter, inc, clr, q), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset: rst=1 mid-run -> if_clear=id_clear=mem_clear=1, keeps=0, counters=0, bus_err=0.
- Load-use: ex_ctrlmem=01, ex_wreg=3, id_rreg2=3 for one cycle, then ex_wreg=F -> exactly 1 cycle of pc_keep=if_keep=id_clear=1; stall_cnt=1. Also ex_wreg=F with id_rreg1=F -> no stall.
- Structural: mem_ctrlmem=10, mem_addr=16'h4000 -> pc_keep=if_clear=1, id_keep=0. With mem_addr=16'hBF00 -> no stall.
- Branch with simultaneous LU and SH: br_taken=1 -> only if_clear=id_clear=1; flush_cnt=1.
- mem_busy high for 3 cycles with br_taken=1 -> 3 full-stall cycles with mem_clear=1, then one flush cycle; stall_cnt=3.
- Timeout with WAIT_MAX=4: mem_busy held 10 cycles -> bus_err=1 after the 4th WAIT cycle and remains 1 after mem_busy drops; clears only on rst.
